// File: rtl/oxi_pkg.sv
// oxi_pkg: types and constants shared by the oximeter controller and the AFE emulator.
// Contents: AFE state enum, converter/code widths, ADC mid-scale, LED-select encoding.
// Latency: n/a (package). Backpressure: n/a.
package oxi_pkg;

  localparam int ADC_W   = 8;
  localparam int DC_W    = 7;
  localparam int GAIN_W  = 4;
  localparam int ADC_MID = 127;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RUN,
    FAULT
  } afe_state_e;

  // LED select packed as {LED_RED, LED_IR}; the controller drives the same encoding.
  typedef enum logic [1:0] {
    LED_OFF      = 2'b00,
    LED_SEL_IR   = 2'b01,
    LED_SEL_RED  = 2'b10,
    LED_SEL_BOTH = 2'b11
  } led_sel_e;

  function automatic led_sel_e led_sel(input logic ir, input logic red);
    return led_sel_e'({red, ir});
  endfunction

endpackage

// File: rtl/afe_emulator_if.sv
// afe_emulator_if: controller <-> analog front end signal bundle.
// master = controller (drives LED selects, DC code, gain code; reads ADC/adc_valid/fault),
// slave = AFE emulator. No handshake: ADC is qualified by adc_valid.
interface afe_emulator_if;
  import oxi_pkg::*;

  logic              LED_IR;
  logic              LED_RED;
  logic [DC_W-1:0]   DC_Comp;
  logic [GAIN_W-1:0] PGA_Gain;
  logic [ADC_W-1:0]  ADC;
  logic              adc_valid;
  logic              fault;

  modport master (
    output LED_IR, LED_RED, DC_Comp, PGA_Gain,
    input  ADC, adc_valid, fault
  );

  modport slave (
    input  LED_IR, LED_RED, DC_Comp, PGA_Gain,
    output ADC, adc_valid, fault
  );

endinterface

// File: rtl/afe_wave_gen.sv
// afe_wave_gen: free-running synthetic heartbeat; triangle over a 7-bit phase, scaled by AC_AMP.
// Ports: clk, rst_n (async active-low), ac_o (6-bit pulsatile amplitude, registered phase -> comb scale).
// Latency: phase steps once every BEAT_DIV cycles; no backpressure.
module afe_wave_gen #(
  parameter int AC_AMP   = 32,
  parameter int BEAT_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [5:0] ac_o
);

  logic [9:0] div_q, div_d;
  logic [6:0] phase_q, phase_d;
  logic [5:0] tri_w;

  always_comb begin
    div_d   = div_q + 10'd1;
    phase_d = phase_q;
    if (div_q == 10'(BEAT_DIV - 1)) begin
      div_d   = '0;
      phase_d = phase_q + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      phase_q <= '0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

  // Upper half of the phase walks the ramp back down.
  assign tri_w = phase_q[6] ? ~phase_q[5:0] : phase_q[5:0];
  assign ac_o  = 6'((12'(tri_w) * 12'(AC_AMP)) >> 6);

endmodule

// File: rtl/afe_emulator.sv
// afe_emulator: photodiode/AFE model answering the oximeter controller (baseline + heartbeat,
//   DC subtraction, PGA gain, saturation to 0..255, settle blanking, dual-LED fault).
// Ports: clk, rst_n (async active-low), afe (slave modport: LED_IR/LED_RED/DC_Comp/PGA_Gain in;
//   ADC/adc_valid/fault out). Latency: input change -> ADC in 2 cycles; adc_valid after
//   SETTLE_CYC+2 quiet cycles. No backpressure. Build option: AFE_NOISE_EN adds LFSR noise.
module afe_emulator
  import oxi_pkg::*;
#(
  parameter int BASE_IR    = 400,
  parameter int BASE_RED   = 320,
  parameter int AC_AMP     = 32,
  parameter int DC_STEP    = 8,
  parameter int BEAT_DIV   = 1000,
  parameter int SETTLE_CYC = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  afe_emulator_if.slave afe
);

  localparam int CNT_W = 8;
  // Blanking plus the two pipeline stages.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYC + 2);

  afe_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DC_W+GAIN_W+1:0] in_w, in_q;
  logic                   change_w;
  led_sel_e               sel_w;
  logic [5:0]             ac_w;

  logic [10:0]      photo_q, photo_d;
  logic [10:0]      dcterm_q, dcterm_d;
  logic [4:0]       gain_q, gain_d;
  logic [ADC_W-1:0] adc_q, adc_d;

  logic signed [11:0] diff_w;
  logic signed [16:0] amp_w;
  logic signed [17:0] sum_w;
  logic signed [17:0] noise_w;

  afe_wave_gen #(
    .AC_AMP  (AC_AMP),
    .BEAT_DIV(BEAT_DIV)
  ) u_wave (
    .clk  (clk),
    .rst_n(rst_n),
    .ac_o (ac_w)
  );

  assign sel_w    = led_sel(afe.LED_IR, afe.LED_RED);
  assign in_w     = {afe.LED_IR, afe.LED_RED, afe.DC_Comp, afe.PGA_Gain};
  // Waveform steps are deliberately absent here: they must not restart settling.
  assign change_w = (in_w != in_q);

`ifdef AFE_NOISE_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign noise_w = 18'($signed({1'b0, lfsr_q[2:0]})) - 18'sd4;
`else
  assign noise_w = '0;
`endif

  // Stage 1: photocurrent, DC term, gain.
  always_comb begin
    photo_d  = (afe.LED_IR ? 11'(BASE_IR) : 11'(BASE_RED)) + 11'(ac_w);
    dcterm_d = 11'(afe.DC_Comp) * 11'(DC_STEP);
    gain_d   = 5'(afe.PGA_Gain) + 5'd1;
  end

  // Stage 2: subtract, amplify, offset to mid-scale, saturate.
  always_comb begin
    diff_w = $signed({1'b0, photo_q}) - $signed({1'b0, dcterm_q});
    amp_w  = 17'(diff_w) * 17'($signed({1'b0, gain_q}));
    sum_w  = 18'(amp_w) + 18'(ADC_MID) + noise_w;
    adc_d  = sum_w[ADC_W-1:0];
    if (sum_w < 18'sd0)        adc_d = '0;
    else if (sum_w > 18'sd255) adc_d = '1;
  end

  // Priority: fault > idle > change event.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sel_w == LED_SEL_BOTH) begin
      state_d = FAULT;
    end else if (sel_w == LED_OFF) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, FAULT: begin
          state_d = SETTLE;
          cnt_d   = RELOAD;
        end
        SETTLE: begin
          if (change_w)                         cnt_d   = RELOAD;
          else if (cnt_q == CNT_W'(1))          state_d = RUN;
          else                                  cnt_d   = cnt_q - CNT_W'(1);
        end
        RUN: begin
          if (change_w) begin
            state_d = SETTLE;
            cnt_d   = RELOAD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      in_q     <= '0;
      photo_q  <= '0;
      dcterm_q <= '0;
      gain_q   <= '0;
      adc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      in_q     <= in_w;
      photo_q  <= photo_d;
      dcterm_q <= dcterm_d;
      gain_q   <= gain_d;
      adc_q    <= adc_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them immediately.
  assign afe.ADC       = (state_q == SETTLE || state_q == RUN) ? adc_q : '0;
  assign afe.adc_valid = (state_q == RUN);
  assign afe.fault     = (state_q == FAULT);

endmodule

// File: tb/tb_afe_emulator.sv
// tb_afe_emulator: table vectors, hand sequences and randomized traffic checked against a
// behavioural model (transfer function + "edges since inputs last changed").
// dut0: AC_AMP=0 (deterministic levels); dut1: AC_AMP=32, BEAT_DIV=4 (waveform ramp).
module tb_afe_emulator;
  import oxi_pkg::*;

  localparam int BASE_IR  = 400;
  localparam int BASE_RED = 320;
  localparam int DC_STEP  = 8;
  localparam int SETTLE   = 4;
  // Edges that must have seen the current inputs before adc_valid is high:
  // the registering edge plus SETTLE+2 blanked cycles.
  localparam int VALID_AGE = SETTLE + 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  afe_emulator_if if0 ();
  afe_emulator_if if1 ();

  afe_emulator #(.BASE_IR(BASE_IR), .BASE_RED(BASE_RED), .AC_AMP(0), .DC_STEP(DC_STEP),
                 .BEAT_DIV(1000), .SETTLE_CYC(SETTLE))
    dut0 (.clk(clk), .rst_n(rst_n), .afe(if0));

  afe_emulator #(.BASE_IR(BASE_IR), .BASE_RED(BASE_RED), .AC_AMP(32), .DC_STEP(DC_STEP),
                 .BEAT_DIV(4), .SETTLE_CYC(SETTLE))
    dut1 (.clk(clk), .rst_n(rst_n), .afe(if1));

  int errors = 0;
  int checks = 0;

  // Model of dut0: applied inputs and number of edges that have seen them.
  logic m_ir = 1'b0, m_red = 1'b0;
  int   m_dc = 0, m_g = 0;
  int   age = 0;

  typedef struct {
    logic ir;
    logic red;
    int   dc;
    int   g;
    int   hold;
    int   exp_adc;    // -1: not checked (pipeline still holds older inputs)
    int   exp_valid;
    int   exp_fault;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_adc(input logic ir, input int dc, input int g);
    int v;
    v = ((ir ? BASE_IR : BASE_RED) - dc * DC_STEP) * (g + 1) + 127;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic drive(input logic ir, input logic red, input int dc, input int g);
    if (ir !== m_ir || red !== m_red || dc != m_dc || g != m_g) age = 0;
    m_ir = ir; m_red = red; m_dc = dc; m_g = g;
    if0.LED_IR   = ir;
    if0.LED_RED  = red;
    if0.DC_Comp  = 7'(dc);
    if0.PGA_Gain = 4'(g);
  endtask

  task automatic tick();
    @(posedge clk);
    if (age < 100000) age++;
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    logic single;
    single = m_ir ^ m_red;
    chk({tag, "_fault"}, int'(if0.fault), int'(m_ir & m_red));
    chk({tag, "_valid"}, int'(if0.adc_valid), int'(single && age >= VALID_AGE));
    if (!single)       chk({tag, "_adc_zero"}, int'(if0.ADC), 0);
    else if (age >= 2) chk({tag, "_adc"}, int'(if0.ADC), exp_adc(m_ir, m_dc, m_g));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, low, viol, g, mn, mx, maxstep, per_err, n158, n127, inval, d;
    int wav[1024];

    // {ir, red, dc, g, hold, adc, valid, fault}
    vecs.push_back('{1'b1, 1'b0,  50,  0, 8, 127, 1, 0});
    vecs.push_back('{1'b1, 1'b0,  40,  0, 8, 207, 1, 0});
    vecs.push_back('{1'b1, 1'b0,  40,  3, 8, 255, 1, 0});  // +320 saturates high
    vecs.push_back('{1'b1, 1'b0,  60,  3, 8,   0, 1, 0});  // -320 saturates low
    vecs.push_back('{1'b1, 1'b0,  35,  0, 8, 247, 1, 0});
    vecs.push_back('{1'b1, 1'b0,  46,  3, 8, 255, 1, 0});  // exactly 255
    vecs.push_back('{1'b1, 1'b0,  66,  0, 8,   0, 1, 0});  // -1 clamps to 0
    vecs.push_back('{1'b1, 1'b0,  65,  0, 8,   7, 1, 0});
    vecs.push_back('{1'b1, 1'b0,  51,  1, 8, 111, 1, 0});
    vecs.push_back('{1'b0, 1'b1,  41,  7, 8,  63, 1, 0});
    vecs.push_back('{1'b0, 1'b1,  30,  1, 8, 255, 1, 0});
    vecs.push_back('{1'b1, 1'b0, 127, 15, 8,   0, 1, 0});
    vecs.push_back('{1'b1, 1'b0,   0,  0, 8, 255, 1, 0});
    vecs.push_back('{1'b1, 1'b1,  40,  0, 1,   0, 0, 1});  // fault on first edge
    vecs.push_back('{1'b1, 1'b1,  40,  0, 6,   0, 0, 1});
    vecs.push_back('{1'b0, 1'b1,  40,  0, 1,  -1, 0, 0});  // leaves fault, settling
    vecs.push_back('{1'b0, 1'b1,  40,  0, 7, 127, 1, 0});  // 320-320 -> mid-scale
    vecs.push_back('{1'b0, 1'b0,  40,  0, 2,   0, 0, 0});

    rst_n = 1'b0;
    if0.LED_IR = 1'b0; if0.LED_RED = 1'b0; if0.DC_Comp = '0; if0.PGA_Gain = '0;
    if1.LED_IR = 1'b1; if1.LED_RED = 1'b0; if1.DC_Comp = 7'd50; if1.PGA_Gain = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_adc", int'(if0.ADC), 0);
    chk("reset_valid", int'(if0.adc_valid), 0);
    chk("reset_fault", int'(if0.fault), 0);
    rst_n = 1'b1;
    age = 0;

    // Waveform on dut1: 127..158 triangle, period 512, valid never drops.
    rise = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (if1.adc_valid) begin rise = i; break; end
    end
    chk("wave_valid_up", int'(if1.adc_valid), 1);
    for (int i = 0; i < 1024; i++) begin
      tick();
      wav[i] = int'(if1.ADC);
      if (!if1.adc_valid) inval++;
    end
    mn = 255; mx = 0; maxstep = 0; per_err = 0; n158 = 0; n127 = 0;
    for (int i = 0; i < 1024; i++) begin
      if (wav[i] < mn) mn = wav[i];
      if (wav[i] > mx) mx = wav[i];
      if (i > 0) begin
        d = wav[i] - wav[i-1];
        if (d < 0) d = -d;
        if (d > maxstep) maxstep = d;
      end
      if (i < 512) begin
        if (wav[i] != wav[i+512]) per_err++;
        if (wav[i] == 158) n158++;
        if (wav[i] == 127) n127++;
      end
    end
    chk("wave_valid_held", inval, 0);
    chk("wave_min", mn, 127);
    chk("wave_max", mx, 158);
    chk("wave_step", maxstep, 1);
    chk("wave_period", per_err, 0);
    chk("wave_peak_cycles", n158, 16);
    chk("wave_floor_cycles", n127, 16);

    // IDLE with a DC code set, then IR rises.
    drive(1'b0, 1'b0, 50, 0);
    tick();
    chk("idle_adc", int'(if0.ADC), 0);
    chk("idle_valid", int'(if0.adc_valid), 0);
    drive(1'b1, 1'b0, 50, 0);
    rise = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (if0.adc_valid) begin rise = i; break; end
    end
    chk("idle_to_run_edges", rise, VALID_AGE);
    chk("idle_to_run_adc", int'(if0.ADC), 127);

    // DC change in RUN: exact ADC latency and blanking length.
    drive(1'b1, 1'b0, 40, 0);
    low = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) chk("lat_edge1_old_adc", int'(if0.ADC), 127);
      if (i == 2) chk("lat_edge2_new_adc", int'(if0.ADC), 207);
      if (if0.adc_valid) break;
      low++;
    end
    chk("run_blank_cycles", low, SETTLE + 2);
    chk("run_resettled_adc", int'(if0.ADC), 207);

    // Gain toggled every 3 cycles: never valid until quiet long enough.
    g = 0; viol = 0;
    for (int c = 0; c < 20; c++) begin
      if (c % 3 == 0) begin g = g ^ 1; drive(1'b1, 1'b0, 40, g); end
      tick();
      if (if0.adc_valid) viol++;
    end
    chk("toggle_valid_low", viol, 0);
    rise = 0;
    for (int i = 3; i <= 20; i++) begin  // two edges already seen since the last toggle
      tick();
      if (if0.adc_valid) begin rise = i; break; end
    end
    chk("toggle_rise_edges", rise, VALID_AGE);
    chk("toggle_adc", int'(if0.ADC), exp_adc(1'b1, 40, g));

    // Table vectors.
    foreach (vecs[k]) begin
      drive(vecs[k].ir, vecs[k].red, vecs[k].dc, vecs[k].g);
      repeat (vecs[k].hold) tick();
      chk($sformatf("vec%0d_fault", k), int'(if0.fault), vecs[k].exp_fault);
      chk($sformatf("vec%0d_valid", k), int'(if0.adc_valid), vecs[k].exp_valid);
      if (vecs[k].exp_adc >= 0)
        chk($sformatf("vec%0d_adc", k), int'(if0.ADC), vecs[k].exp_adc);
    end

    // Reset mid-operation clears outputs at once, then the block resettles.
    drive(1'b1, 1'b0, 45, 2);
    repeat (9) tick();
    chk("pre_reset_valid", int'(if0.adc_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_adc", int'(if0.ADC), 0);
    chk("midreset_valid", int'(if0.adc_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    age = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_model("post_reset");
    end

    // Randomized traffic against the model.
    for (int s = 0; s < 250; s++) begin
      int r, dc, gg, hold;
      logic ir, red;
      r = int'($urandom_range(0, 9));
      ir  = (r < 4) || (r == 8);
      red = (r >= 4 && r < 8) || (r == 8);
      if ($urandom_range(0, 3) != 0) dc = (ir ? 50 : 40) + int'($urandom_range(0, 20)) - 10;
      else                          dc = int'($urandom_range(0, 127));
      gg   = int'($urandom_range(0, 15));
      hold = int'($urandom_range(1, 10));
      drive(ir, red, dc, gg);
      for (int h = 0; h < hold; h++) begin
        tick();
        check_model("rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
